// File: rtl/ex.sv
// ============================================================================
// Module   : ex
// Purpose  : SWT16 execute stage. Computes ALU results and DMEM addresses and
//            registers all control and data for the mem stage. MUL is an
//            iterative shift-add multiply that stalls upstream, or a
//            single-cycle product when FAST_MUL_EN is defined.
// Config   : FAST_MUL_EN (define for single-cycle MUL, no stall)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex #(
  parameter int DMEM_ADDR_WIDTH = 12,
  parameter int DMEM_WORD_WIDTH = 16,
  parameter int IALU_WORD_WIDTH = 16,
  parameter int REG_IDX_WIDTH   = 4,
  parameter int ALU_OP_WIDTH    = 4,
  parameter int SHAMT_WIDTH     = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [ALU_OP_WIDTH-1:0]    in_alu_op,
  input  logic [IALU_WORD_WIDTH-1:0] in_op_a,
  input  logic [IALU_WORD_WIDTH-1:0] in_op_b,
  input  logic [IALU_WORD_WIDTH-1:0] in_imm,
  input  logic                       in_act_load_dmem,
  input  logic                       in_act_store_dmem,
  input  logic                       in_act_write_res_to_reg,
  input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
  output logic                       out_stall,
  output logic                       out_act_load_dmem,
  output logic                       out_act_store_dmem,
  output logic                       out_act_write_res_to_reg,
  output logic [DMEM_ADDR_WIDTH-1:0] out_mem_rd_addr,
  output logic [DMEM_ADDR_WIDTH-1:0] out_mem_wr_addr,
  output logic [DMEM_WORD_WIDTH-1:0] out_mem_wr_word,
  output logic [IALU_WORD_WIDTH-1:0] out_res,
  output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx
);

  localparam logic [ALU_OP_WIDTH-1:0] OP_ADD   = ALU_OP_WIDTH'(0);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SUB   = ALU_OP_WIDTH'(1);
  localparam logic [ALU_OP_WIDTH-1:0] OP_AND   = ALU_OP_WIDTH'(2);
  localparam logic [ALU_OP_WIDTH-1:0] OP_OR    = ALU_OP_WIDTH'(3);
  localparam logic [ALU_OP_WIDTH-1:0] OP_XOR   = ALU_OP_WIDTH'(4);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SLL   = ALU_OP_WIDTH'(5);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SRL   = ALU_OP_WIDTH'(6);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SRA   = ALU_OP_WIDTH'(7);
  localparam logic [ALU_OP_WIDTH-1:0] OP_MUL   = ALU_OP_WIDTH'(8);
  localparam logic [ALU_OP_WIDTH-1:0] OP_PASSB = ALU_OP_WIDTH'(9);

  logic [IALU_WORD_WIDTH-1:0] alu_res_d;
  logic [IALU_WORD_WIDTH-1:0] addr_sum_d;
  logic [DMEM_ADDR_WIDTH-1:0] addr_d;
  logic [SHAMT_WIDTH-1:0]     shamt_d;
  logic                       unused_addr_hi;

  assign shamt_d        = in_op_b[SHAMT_WIDTH-1:0];
  // Address is summed at full ALU width, then only the low DMEM bits are kept.
  assign addr_sum_d     = in_op_a + in_imm;
  assign addr_d         = addr_sum_d[DMEM_ADDR_WIDTH-1:0];
  assign unused_addr_hi = ^addr_sum_d[IALU_WORD_WIDTH-1:DMEM_ADDR_WIDTH];

  // Single-cycle ALU; undefined opcodes yield zero.
  always_comb begin
    alu_res_d = '0;
    case (in_alu_op)
      OP_ADD:   alu_res_d = in_op_a + in_op_b;
      OP_SUB:   alu_res_d = in_op_a - in_op_b;
      OP_AND:   alu_res_d = in_op_a & in_op_b;
      OP_OR:    alu_res_d = in_op_a | in_op_b;
      OP_XOR:   alu_res_d = in_op_a ^ in_op_b;
      OP_SLL:   alu_res_d = in_op_a << shamt_d;
      OP_SRL:   alu_res_d = in_op_a >> shamt_d;
      OP_SRA:   alu_res_d = $unsigned($signed(in_op_a) >>> shamt_d);
`ifdef FAST_MUL_EN
      OP_MUL:   alu_res_d = in_op_a * in_op_b;
`else
      OP_MUL:   alu_res_d = '0;
`endif
      OP_PASSB: alu_res_d = in_op_b;
      default:  alu_res_d = '0;
    endcase
  end

`ifdef FAST_MUL_EN

  assign out_stall = 1'b0;

  // Output register: every accepted instruction lands one edge later.
  always_ff @(posedge clock) begin
    if (reset || !in_valid) begin
      out_act_load_dmem        <= 1'b0;
      out_act_store_dmem       <= 1'b0;
      out_act_write_res_to_reg <= 1'b0;
      out_mem_rd_addr          <= '0;
      out_mem_wr_addr          <= '0;
      out_mem_wr_word          <= '0;
      out_res                  <= '0;
      out_res_reg_idx          <= '0;
    end else begin
      out_act_load_dmem        <= in_act_load_dmem;
      out_act_store_dmem       <= in_act_store_dmem;
      out_act_write_res_to_reg <= in_act_write_res_to_reg;
      out_mem_rd_addr          <= in_act_load_dmem  ? addr_d : '0;
      out_mem_wr_addr          <= in_act_store_dmem ? addr_d : '0;
      out_mem_wr_word          <= in_act_store_dmem ? in_op_b[DMEM_WORD_WIDTH-1:0] : '0;
      out_res                  <= alu_res_d;
      out_res_reg_idx          <= in_res_reg_idx;
    end
  end

`else

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t                     state_q;
  logic [SHAMT_WIDTH-1:0]     count_q;
  logic [IALU_WORD_WIDTH-1:0] mcand_q;
  logic [IALU_WORD_WIDTH-1:0] mplier_q;
  logic [IALU_WORD_WIDTH-1:0] acc_q;
  logic [REG_IDX_WIDTH-1:0]   mul_idx_q;
  logic                       mul_wr_q;
  logic [IALU_WORD_WIDTH-1:0] acc_d;

  assign out_stall = (state_q == S_MUL);

  // One shift-add step: the final edge emits this value so all W bits count.
  assign acc_d = mcand_q[0] ? (acc_q + mplier_q) : acc_q;

  // Execute FSM with registered mem-stage outputs; bubble is the default load.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q                  <= S_IDLE;
      count_q                  <= '0;
      mcand_q                  <= '0;
      mplier_q                 <= '0;
      acc_q                    <= '0;
      mul_idx_q                <= '0;
      mul_wr_q                 <= 1'b0;
      out_act_load_dmem        <= 1'b0;
      out_act_store_dmem       <= 1'b0;
      out_act_write_res_to_reg <= 1'b0;
      out_mem_rd_addr          <= '0;
      out_mem_wr_addr          <= '0;
      out_mem_wr_word          <= '0;
      out_res                  <= '0;
      out_res_reg_idx          <= '0;
    end else begin
      out_act_load_dmem        <= 1'b0;
      out_act_store_dmem       <= 1'b0;
      out_act_write_res_to_reg <= 1'b0;
      out_mem_rd_addr          <= '0;
      out_mem_wr_addr          <= '0;
      out_mem_wr_word          <= '0;
      out_res                  <= '0;
      out_res_reg_idx          <= '0;
      case (state_q)
        S_IDLE: begin
          if (in_valid && (in_alu_op == OP_MUL)) begin
            mplier_q  <= in_op_a;
            mcand_q   <= in_op_b;
            acc_q     <= '0;
            mul_idx_q <= in_res_reg_idx;
            mul_wr_q  <= in_act_write_res_to_reg;
            count_q   <= SHAMT_WIDTH'(IALU_WORD_WIDTH - 1);
            state_q   <= S_MUL;
          end else if (in_valid) begin
            out_act_load_dmem        <= in_act_load_dmem;
            out_act_store_dmem       <= in_act_store_dmem;
            out_act_write_res_to_reg <= in_act_write_res_to_reg;
            out_mem_rd_addr          <= in_act_load_dmem  ? addr_d : '0;
            out_mem_wr_addr          <= in_act_store_dmem ? addr_d : '0;
            out_mem_wr_word          <= in_act_store_dmem ? in_op_b[DMEM_WORD_WIDTH-1:0] : '0;
            out_res                  <= alu_res_d;
            out_res_reg_idx          <= in_res_reg_idx;
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q << 1;
          mcand_q  <= mcand_q >> 1;
          count_q  <= count_q - 1'b1;
          if (count_q == '0) begin
            out_res                  <= acc_d;
            out_res_reg_idx          <= mul_idx_q;
            out_act_write_res_to_reg <= mul_wr_q;
            state_q                  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`endif

endmodule

`default_nettype wire

// File: tb/tb_ex.sv
// ============================================================================
// Module   : tb_ex
// Purpose  : Directed self-checking bench for the ex stage (both MUL builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [3:0]  in_alu_op;
  logic [15:0] in_op_a, in_op_b, in_imm;
  logic        in_act_load_dmem, in_act_store_dmem, in_act_write_res_to_reg;
  logic [3:0]  in_res_reg_idx;
  logic        out_stall;
  logic        out_act_load_dmem, out_act_store_dmem, out_act_write_res_to_reg;
  logic [11:0] out_mem_rd_addr, out_mem_wr_addr;
  logic [15:0] out_mem_wr_word, out_res;
  logic [3:0]  out_res_reg_idx;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  ex dut (
    .clock                    (clock),
    .reset                    (reset),
    .in_valid                 (in_valid),
    .in_alu_op                (in_alu_op),
    .in_op_a                  (in_op_a),
    .in_op_b                  (in_op_b),
    .in_imm                   (in_imm),
    .in_act_load_dmem         (in_act_load_dmem),
    .in_act_store_dmem        (in_act_store_dmem),
    .in_act_write_res_to_reg  (in_act_write_res_to_reg),
    .in_res_reg_idx           (in_res_reg_idx),
    .out_stall                (out_stall),
    .out_act_load_dmem        (out_act_load_dmem),
    .out_act_store_dmem       (out_act_store_dmem),
    .out_act_write_res_to_reg (out_act_write_res_to_reg),
    .out_mem_rd_addr          (out_mem_rd_addr),
    .out_mem_wr_addr          (out_mem_wr_addr),
    .out_mem_wr_word          (out_mem_wr_word),
    .out_res                  (out_res),
    .out_res_reg_idx          (out_res_reg_idx)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] imm, input logic ld,
                       input logic st, input logic wr, input logic [3:0] idx);
    in_valid = v; in_alu_op = op; in_op_a = a; in_op_b = b; in_imm = imm;
    in_act_load_dmem = ld; in_act_store_dmem = st;
    in_act_write_res_to_reg = wr; in_res_reg_idx = idx;
  endtask

  task automatic test_reset();
    drive(1'b1, 4'd9, 16'h0000, 16'hA5A5, 16'h0000, 1'b1, 1'b1, 1'b1, 4'hF);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b0, 4'd0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    n_checks++;
    if ({out_act_load_dmem, out_act_store_dmem, out_act_write_res_to_reg, out_mem_rd_addr,
         out_mem_wr_addr, out_mem_wr_word, out_res, out_res_reg_idx, out_stall} !== 76'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: res=%h rd=%h wr=%h word=%h idx=%h stall=%b, required all zero",
               out_res, out_mem_rd_addr, out_mem_wr_addr, out_mem_wr_word, out_res_reg_idx, out_stall);
    end
  endtask

  task automatic test_add();
    drive(1'b1, 4'd0, 16'h0003, 16'h0004, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd5);
    tick();
    n_checks++;
    if ({out_res, out_res_reg_idx, out_act_write_res_to_reg} !== {16'h0007, 4'd5, 1'b1}) begin
      n_fail++;
      $display("FAIL add: res=%h idx=%0d wr=%b, required 0007 5 1",
               out_res, out_res_reg_idx, out_act_write_res_to_reg);
    end
  endtask

  task automatic test_alu();
    logic [3:0]  ops [7];
    logic [15:0] as  [7];
    logic [15:0] bs  [7];
    logic [15:0] exp [7];
    ops = '{4'd1, 4'd7, 4'd6, 4'd5, 4'd4, 4'd9, 4'd12};
    as  = '{16'h0000, 16'h8000, 16'h8000, 16'h0003, 16'hF0F0, 16'h1234, 16'hFFFF};
    bs  = '{16'h0001, 16'h0004, 16'h0004, 16'h0013, 16'hFF00, 16'hCAFE, 16'hFFFF};
    exp = '{16'hFFFF, 16'hF800, 16'h0800, 16'h0018, 16'h0FF0, 16'hCAFE, 16'h0000};
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, ops[i], as[i], bs[i], 16'h0000, 1'b0, 1'b0, 1'b1, 4'd2);
      tick();
      n_checks++;
      if ({out_res, out_act_write_res_to_reg} !== {exp[i], 1'b1}) begin
        n_fail++;
        $display("FAIL alu_op%0d: res=%h wr=%b, required %h 1",
                 ops[i], out_res, out_act_write_res_to_reg, exp[i]);
      end
    end
  endtask

  task automatic test_mem();
    drive(1'b1, 4'd0, 16'h0100, 16'hBEEF, 16'h00F4, 1'b0, 1'b1, 1'b0, 4'd0);
    tick();
    n_checks++;
    if ({out_mem_wr_addr, out_mem_wr_word, out_act_store_dmem, out_mem_rd_addr, out_act_load_dmem}
        !== {12'h1F4, 16'hBEEF, 1'b1, 12'h000, 1'b0}) begin
      n_fail++;
      $display("FAIL store: wa=%h word=%h st=%b ra=%h ld=%b, required 1f4 beef 1 000 0",
               out_mem_wr_addr, out_mem_wr_word, out_act_store_dmem, out_mem_rd_addr, out_act_load_dmem);
    end
    drive(1'b1, 4'd0, 16'h0FFF, 16'h5555, 16'h0002, 1'b1, 1'b0, 1'b1, 4'd1);
    tick();
    n_checks++;
    if ({out_mem_rd_addr, out_act_load_dmem, out_mem_wr_addr, out_mem_wr_word, out_act_store_dmem}
        !== {12'h001, 1'b1, 12'h000, 16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL load: ra=%h ld=%b wa=%h word=%h st=%b, required 001 1 000 0000 0",
               out_mem_rd_addr, out_act_load_dmem, out_mem_wr_addr, out_mem_wr_word, out_act_store_dmem);
    end
  endtask

  task automatic test_bubble();
    drive(1'b0, 4'd0, 16'h1111, 16'h2222, 16'h0010, 1'b1, 1'b1, 1'b1, 4'd9);
    tick();
    n_checks++;
    if ({out_act_load_dmem, out_act_store_dmem, out_act_write_res_to_reg, out_res,
         out_mem_rd_addr, out_mem_wr_addr, out_mem_wr_word, out_res_reg_idx} !== 71'd0) begin
      n_fail++;
      $display("FAIL bubble: ld=%b st=%b wr=%b res=%h idx=%h, required all zero",
               out_act_load_dmem, out_act_store_dmem, out_act_write_res_to_reg, out_res, out_res_reg_idx);
    end
  endtask

  // MUL followed by an ADD that upstream holds until the stall clears.
  task automatic test_mul(input logic [15:0] a, input logic [15:0] b, input logic [15:0] prod);
    int  stall_cycles;
    logic acts_seen;
    drive(1'b1, 4'd8, a, b, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd7);
    tick();
    drive(1'b1, 4'd0, 16'h0001, 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd3);
    stall_cycles = 0;
    acts_seen    = 1'b0;
    while (out_stall === 1'b1 && stall_cycles < 40) begin
      if (out_act_load_dmem || out_act_store_dmem || out_act_write_res_to_reg) acts_seen = 1'b1;
      tick();
      stall_cycles++;
    end
`ifdef FAST_MUL_EN
    n_checks++;
    if (stall_cycles !== 0) begin
      n_fail++;
      $display("FAIL fast_mul_stall: stalled %0d cycles, required 0", stall_cycles);
    end
`else
    n_checks++;
    if (stall_cycles !== 16) begin
      n_fail++;
      $display("FAIL mul_stall_len: stalled %0d cycles, required 16", stall_cycles);
    end
    n_checks++;
    if (acts_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_bubbles: act seen during stall=%b, required 0", acts_seen);
    end
`endif
    n_checks++;
    if ({out_res, out_res_reg_idx, out_act_write_res_to_reg} !== {prod, 4'd7, 1'b1}) begin
      n_fail++;
      $display("FAIL mul_result: res=%h idx=%0d wr=%b, required %h 7 1",
               out_res, out_res_reg_idx, out_act_write_res_to_reg, prod);
    end
    tick();
    drive(1'b0, 4'd0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    n_checks++;
    if ({out_res, out_res_reg_idx, out_act_write_res_to_reg, out_stall} !== {16'h0003, 4'd3, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL mul_then_add: res=%h idx=%0d wr=%b stall=%b, required 0003 3 1 0",
               out_res, out_res_reg_idx, out_act_write_res_to_reg, out_stall);
    end
  endtask

  task automatic test_mul_reset();
    logic leaked;
    drive(1'b1, 4'd8, 16'h0123, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd7);
    tick();
    drive(1'b0, 4'd0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if ({out_act_load_dmem, out_act_store_dmem, out_act_write_res_to_reg, out_res,
         out_res_reg_idx, out_stall} !== 24'd0) begin
      n_fail++;
      $display("FAIL mul_abort_reset: res=%h wr=%b idx=%h stall=%b, required all zero",
               out_res, out_act_write_res_to_reg, out_res_reg_idx, out_stall);
    end
    leaked = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (out_act_write_res_to_reg || out_res != 16'h0 || out_stall) leaked = 1'b1;
    end
    n_checks++;
    if (leaked !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_abort_no_result: leaked=%b, required 0", leaked);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 4'd0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    tick();
    test_reset();
    test_add();
    test_alu();
    test_mem();
    test_bubble();
    test_mul(16'h0123, 16'h0010, 16'h1230);
    test_mul(16'hFFFF, 16'hFFFF, 16'h0001);
    test_mul_reset();
    test_add();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
